// File: rtl/dmem_mmio_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_mmio_responder_pkg
//  Purpose  : Shared MMIO offsets, status-bit layout and key-code width for
//             the data-memory MMIO responder.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_mmio_responder_pkg;

   localparam int KEY_W = 8;

   typedef enum logic [1:0] {
      OFF_STATUS = 2'd0,
      OFF_KEY    = 2'd1,
      OFF_LED    = 2'd2,
      OFF_CYCLES = 2'd3
   } mmio_off_e;

   localparam int ST_NONEMPTY = 0;
   localparam int ST_OVF      = 1;
   localparam int ST_COUNT_LO = 4;
   localparam int ST_COUNT_W  = 4;

   function automatic logic [31:0] status_word(input logic                  nonempty,
                                               input logic                  ovf,
                                               input logic [ST_COUNT_W-1:0] cnt);
      logic [31:0] w_word;
      w_word                             = '0;
      w_word[ST_NONEMPTY]                = nonempty;
      w_word[ST_OVF]                     = ovf;
      w_word[ST_COUNT_LO +: ST_COUNT_W]  = cnt;
      return w_word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_mmio_responder_if
//  Purpose  : Data-memory port plus keyboard-input handshake between the
//             processor memory stage and the MMIO responder.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_mmio_responder_if;
   import dmem_mmio_responder_pkg::*;

   logic [31:0]      address_dmem;
   logic [31:0]      data;
   logic             wren;
   logic             rden;
   logic [31:0]      q_dmem;
   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic             key_ready;

   modport master (
      output address_dmem, data, wren, rden, key_valid, key_code,
      input  q_dmem, key_ready
   );

   modport slave (
      input  address_dmem, data, wren, rden, key_valid, key_code,
      output q_dmem, key_ready
   );

endinterface
`default_nettype wire

// File: rtl/dmem_mmio_responder_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_mmio_responder_key_fifo
//  Purpose  : Small keyboard-character FIFO with show-ahead head output.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder_key_fifo
   import dmem_mmio_responder_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [KEY_W-1:0] din,
   input  logic             pop,
   output logic [KEY_W-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [KEY_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage has no reset; the pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_mmio_responder
//  Purpose  : Data-memory responder: word RAM below DEPTH plus an MMIO window
//             (status, key FIFO, LED, optional cycle counter).
//  Options  : DMEM_MMIO_CYCLE_COUNTER_EN adds the free-running CYCLES register.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder
   import dmem_mmio_responder_pkg::*;
#(
   parameter int          DEPTH      = 4096,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h0000F000
) (
   input  logic                     clock,
   input  logic                     reset,
   dmem_mmio_responder_if.slave     bus,
   output logic [31:0]              led_out
);

   localparam int c_RAM_AW = $clog2(DEPTH);
   localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

   logic [31:0]         r_mem [DEPTH];
   logic [31:0]         r_q;
   logic [31:0]         r_led;
   logic                r_ovf;

   logic                w_ram_hit;
   logic                w_mmio_hit;
   logic [31:0]         w_off;
   mmio_off_e           w_reg;
   logic [c_RAM_AW-1:0] w_ram_idx;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_key_ready;
   logic [KEY_W-1:0]    w_head;
   logic [c_CNT_W-1:0]  w_count;
   logic                w_wr_status;
   logic                w_wr_led;
   logic [31:0]         w_cycles_rd;
   logic [31:0]         w_mmio_rdata;

   assign w_ram_hit   = (bus.address_dmem < 32'(DEPTH));
   assign w_ram_idx   = bus.address_dmem[c_RAM_AW-1:0];
   assign w_off       = bus.address_dmem - MMIO_BASE;
   assign w_mmio_hit  = (bus.address_dmem >= MMIO_BASE) && (w_off[31:2] == '0);
   assign w_reg       = mmio_off_e'(w_off[1:0]);

   assign w_wr_status = bus.wren && w_mmio_hit && (w_reg == OFF_STATUS);
   assign w_wr_led    = bus.wren && w_mmio_hit && (w_reg == OFF_LED);
   assign w_key_ready = !w_full;
   assign w_push      = bus.key_valid && w_key_ready;
   // An empty FIFO is never popped, so a same-cycle push into it survives.
   assign w_pop       = bus.rden && w_mmio_hit && (w_reg == OFF_KEY) && !w_empty;

   dmem_mmio_responder_key_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .din   (bus.key_code),
      .pop   (w_pop),
      .dout  (w_head),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
   logic        r_cycles;
   logic [31:0] r_cycle_cnt;
   logic        w_wr_cycles;

   assign w_wr_cycles = bus.wren && w_mmio_hit && (w_reg == OFF_CYCLES);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cycle_cnt <= '0;
         r_cycles    <= 1'b0;
      end else begin
         r_cycles <= 1'b1;
         if (w_wr_cycles) r_cycle_cnt <= bus.data;
         else             r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   // A read reports the value the counter takes on the sampling edge.
   assign w_cycles_rd = r_cycle_cnt + 32'd1;
`else
   assign w_cycles_rd = '0;
`endif

   always_comb begin
      w_mmio_rdata = '0;
      if (w_mmio_hit) begin
         case (w_reg)
            OFF_STATUS: w_mmio_rdata = status_word(!w_empty, r_ovf, ST_COUNT_W'(w_count));
            OFF_KEY:    w_mmio_rdata = w_empty ? '0 : {{(32-KEY_W){1'b0}}, w_head};
            OFF_LED:    w_mmio_rdata = r_led;
            OFF_CYCLES: w_mmio_rdata = w_cycles_rd;
            default:    w_mmio_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (bus.wren && w_ram_hit) r_mem[w_ram_idx] <= bus.data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q   <= '0;
         r_led <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_q <= w_ram_hit ? r_mem[w_ram_idx] : w_mmio_rdata;
         if (w_wr_led) r_led <= bus.data;
         // A dropped key outranks a software clear in the same cycle.
         if (bus.key_valid && !w_key_ready)         r_ovf <= 1'b1;
         else if (w_wr_status && bus.data[ST_OVF])  r_ovf <= 1'b0;
      end
   end

   assign bus.q_dmem    = r_q;
   assign bus.key_ready = w_key_ready;
   assign led_out       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_mmio_responder
//  Purpose  : Directed bench for dmem_mmio_responder (vector table plus
//             hand-written FIFO-full, reset and cycle-counter sequences).
//  Options  : DMEM_MMIO_CYCLE_COUNTER_EN selects the CYCLES expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

   localparam logic [31:0] MB   = 32'h0000F000;
   localparam logic [31:0] ST   = MB;
   localparam logic [31:0] KEY  = MB + 32'd1;
   localparam logic [31:0] LED  = MB + 32'd2;
   localparam logic [31:0] CYC  = MB + 32'd3;
   localparam logic [31:0] NOP  = MB + 32'd5;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wren;
      logic        rden;
      logic        kv;
      logic [7:0]  kc;
      logic        chk_q;
      logic [31:0] exp_q;
      logic        exp_ready;
   } vec_t;

   logic        clock;
   logic        reset;
   logic [31:0] led_out;
   int          n_checks;
   int          n_errors;
   vec_t        vecs[$];

   dmem_mmio_responder_if bus();

   dmem_mmio_responder dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .led_out (led_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic re, input logic kv, input logic [7:0] kc);
      bus.address_dmem = a;
      bus.data         = d;
      bus.wren         = we;
      bus.rden         = re;
      bus.key_valid    = kv;
      bus.key_code     = kc;
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re,
                      input logic kv, input logic [7:0] kc, input logic chk, input logic [31:0] eq);
      vec_t v;
      v.addr = a; v.data = d; v.wren = we; v.rden = re; v.kv = kv; v.kc = kc;
      v.chk_q = chk; v.exp_q = eq; v.exp_ready = 1'b1;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] exp_cyc;
      n_checks = 0;
      n_errors = 0;

      // RAM: preload, read-after-write, read-during-write, boundaries
      add(32'd6,    32'h0,        1, 0, 0, 8'h00, 0, 32'h0);
      add(32'd5,    32'hDEADBEEF, 1, 0, 0, 8'h00, 0, 32'h0);
      add(32'd5,    32'h0,        0, 1, 0, 8'h00, 1, 32'hDEADBEEF);
      add(32'd6,    32'h0,        0, 1, 0, 8'h00, 1, 32'h0);
      add(32'd5,    32'h12345678, 1, 1, 0, 8'h00, 1, 32'hDEADBEEF);
      add(32'd5,    32'h0,        0, 0, 0, 8'h00, 1, 32'h12345678);
      add(32'd0,    32'h11,       1, 0, 0, 8'h00, 0, 32'h0);
      add(32'd4095, 32'hA5A5A5A5, 1, 0, 0, 8'h00, 0, 32'h0);
      add(32'd4096, 32'hFF,       1, 1, 0, 8'h00, 1, 32'h0);
      add(32'd0,    32'h0,        0, 1, 0, 8'h00, 1, 32'h11);
      add(32'd4095, 32'h0,        0, 1, 0, 8'h00, 1, 32'hA5A5A5A5);
      add(32'd4096, 32'h0,        0, 1, 0, 8'h00, 1, 32'h0);
      add(MB - 1,   32'h0,        0, 1, 0, 8'h00, 1, 32'h0);
      add(MB + 4,   32'h77,       1, 1, 0, 8'h00, 1, 32'h0);
      // CRANE through the key FIFO
      add(NOP, 0, 0, 0, 1, 8'h43, 1, 32'h0);
      add(NOP, 0, 0, 0, 1, 8'h52, 1, 32'h0);
      add(NOP, 0, 0, 0, 1, 8'h41, 1, 32'h0);
      add(NOP, 0, 0, 0, 1, 8'h4E, 1, 32'h0);
      add(NOP, 0, 0, 0, 1, 8'h45, 1, 32'h0);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h51);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h43);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h52);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h41);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h4E);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h45);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h00);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h00);
      // push into empty while reading KEY_DATA
      add(KEY, 0, 0, 1, 1, 8'h5A, 1, 32'h00);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h11);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h5A);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h00);
      // simultaneous push/pop with three queued, then peek without rden
      add(NOP, 0, 0, 0, 1, 8'h41, 1, 32'h0);
      add(NOP, 0, 0, 0, 1, 8'h42, 1, 32'h0);
      add(NOP, 0, 0, 0, 1, 8'h43, 1, 32'h0);
      add(KEY, 0, 0, 1, 1, 8'h44, 1, 32'h41);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h31);
      add(KEY, 0, 0, 0, 0, 8'h00, 1, 32'h42);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h31);
      add(KEY, 32'h99, 1, 1, 0, 8'h00, 1, 32'h42);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h43);
      add(KEY, 0, 0, 1, 0, 8'h00, 1, 32'h44);
      add(ST,  0, 0, 1, 0, 8'h00, 1, 32'h00);
      // LED write returns the pre-write value, read returns the new one
      add(LED, 32'h1F, 1, 1, 0, 8'h00, 1, 32'h0);
      add(LED, 0,      0, 1, 0, 8'h00, 1, 32'h1F);

      reset = 1'b0;
      drive(32'h0, 32'h0, 0, 0, 0, 8'h00);
      repeat (2) @(negedge clock);
      check("reset_q", bus.q_dmem, 32'h0);
      check("reset_led", led_out, 32'h0);
      check("reset_ready", {31'b0, bus.key_ready}, 32'h1);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].addr, vecs[i].data, vecs[i].wren, vecs[i].rden, vecs[i].kv, vecs[i].kc);
         step();
         if (vecs[i].chk_q) check($sformatf("vec%0d_q", i), bus.q_dmem, vecs[i].exp_q);
         check($sformatf("vec%0d_ready", i), {31'b0, bus.key_ready}, {31'b0, vecs[i].exp_ready});
      end
      check("led_after_vectors", led_out, 32'h1F);

      // Fill to full with key_valid held; last two keys are dropped
      for (int i = 1; i <= 10; i++) begin
         drive(NOP, 0, 0, 0, 1, 8'(8'h60 + i));
         step();
         check($sformatf("fill%0d_ready", i), {31'b0, bus.key_ready}, (i < 8) ? 32'h1 : 32'h0);
      end
      drive(ST, 0, 0, 1, 0, 8'h00); step();
      check("full_status", bus.q_dmem, 32'h83);
      drive(ST, 32'h2, 1, 0, 1, 8'h7F); step();
      drive(ST, 0, 0, 1, 0, 8'h00); step();
      check("ovf_set_wins", bus.q_dmem, 32'h83);
      drive(ST, 32'h2, 1, 0, 0, 8'h00); step();
      drive(ST, 0, 0, 1, 0, 8'h00); step();
      check("ovf_cleared", bus.q_dmem, 32'h81);
      for (int i = 1; i <= 8; i++) begin
         drive(KEY, 0, 0, 1, 0, 8'h00); step();
         check($sformatf("drain%0d", i), bus.q_dmem, 32'(8'h60 + i));
      end
      drive(ST, 0, 0, 1, 0, 8'h00); step();
      check("drained_status", bus.q_dmem, 32'h00);

      // Mid-burst asynchronous reset
      drive(LED, 32'h0000001F, 1, 0, 0, 8'h00); step();
      check("led_written", led_out, 32'h1F);
      for (int i = 0; i < 8; i++) begin
         drive(NOP, 0, 0, 0, 1, 8'(8'h30 + i)); step();
      end
      check("prereset_ready", {31'b0, bus.key_ready}, 32'h0);
      drive(LED, 0, 0, 1, 1, 8'h39); step();
      check("prereset_q", bus.q_dmem, 32'h1F);
      #2 reset = 1'b0;
      #1;
      check("async_led", led_out, 32'h0);
      check("async_ready", {31'b0, bus.key_ready}, 32'h1);
      check("async_q", bus.q_dmem, 32'h0);
      drive(ST, 0, 0, 1, 0, 8'h00);
      @(negedge clock);
      reset = 1'b1;
      step();
      check("post_reset_status", bus.q_dmem, 32'h00);

      // Cycle counter
      drive(CYC, 32'd100, 1, 0, 0, 8'h00); step();
      drive(CYC, 0, 0, 1, 0, 8'h00);
      for (int i = 1; i <= 3; i++) begin
         step();
`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
         exp_cyc = 32'd100 + 32'(i);
`else
         exp_cyc = 32'd0;
`endif
         check($sformatf("cycles%0d", i), bus.q_dmem, exp_cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder side of the processor's data-memory port. It services every load/store the memory stage issues on address_dmem/data/wren, and returns q_dmem.
- Word-addressed RAM backs the low address space.
- A small MMIO window exposes a keyboard-input FIFO (guess letters), a status register and an output register for the game display.
- Instantiated in Wrapper in place of the plain dmem.

Parameters:
- DEPTH, 4096, number of 32-bit RAM words; valid RAM addresses are 0..DEPTH-1.
- FIFO_DEPTH, 8, key FIFO entries; power of two, at most 15.
- MMIO_BASE, 32'h0000F000, word address of the first MMIO register.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_dmem  in  32  word address from the memory stage.
- data  in  32  store data.
- wren  in  1  store enable.
- rden  in  1  load enable; Wrapper decodes it from the memory-stage lw opcode. Gates all read side effects.
- q_dmem  out  32  load data.
- key_valid  in  1  keyboard character offered.
- key_code  in  8  ASCII code of the offered character.
- key_ready  out  1  FIFO can accept; a push occurs when key_valid && key_ready.
- led_out  out  32  display/output register.

Behaviour:
- Reset (reset low, asynchronous):
  - q_dmem=0, led_out=0, FIFO empty (count=0), overflow=0, cycle counter=0.
  - RAM contents are not cleared.
- Latency:
  - q_dmem is registered; it updates on the rising edge that samples address_dmem.
  - The processor captures q_dmem at the following falling edge, so effective latency is one half-cycle.
- RAM region (address < DEPTH):
  - Write when wren.
  - A read is registered every cycle regardless of rden.
  - Read-during-write to the same address returns the old data.
- MMIO map (word offsets from MMIO_BASE):
  - +0 STATUS, read: bit0 = FIFO non-empty, bit1 = overflow, bits[7:4] = count, others 0.
  - +0 STATUS, write: data bit1=1 clears overflow.
  - +1 KEY_DATA, read with rden: returns {24'b0, head code} and pops one entry.
  - +1 KEY_DATA, read while empty: returns 0, no pop.
  - +1 KEY_DATA, read with rden=0: returns the head code without popping. Writes are ignored.
  - +2 LED, read returns led_out; write loads led_out from data.
  - +3 CYCLES: see Optional Feature.
  - Other MMIO offsets: read 0, writes ignored.
- Any other address: read 0, write ignored.
- FIFO:
  - key_ready = (count != FIFO_DEPTH); it is a combinational function of registered count.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Push into an empty FIFO in the same cycle as a KEY_DATA read: the read returns 0, and the pushed entry lands with count=1.
  - key_valid while full: no push, overflow set (sticky).
  - Overflow set and clear in the same cycle: set wins.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- wren and rden both high on one address: the write executes and the read returns the pre-write value. A KEY_DATA pop still occurs.
- Reset asserted mid-operation discards the FIFO contents and any in-flight load result.

Optional Feature:
- Macro: DMEM_MMIO_CYCLE_COUNTER_EN.
- Defined:
  - A 32-bit free-running counter increments every clock and wraps at 2^32.
  - A read of +3 returns its value at the sampling edge, used as the game's random seed.
  - A write of +3 loads the counter from data.
- Undefined: +3 reads 0, writes are ignored, and no counter flops are present.

Decomposition:
- Shared package:
  - MMIO offset constants (OFF_STATUS=0, OFF_KEY=1, OFF_LED=2, OFF_CYCLES=3).
  - Status bit positions (ST_NONEMPTY=0, ST_OVF=1, ST_COUNT_LO=4).
  - Key-code width 8.
- Sub-module key_fifo:
  - Parameter FIFO_DEPTH.
  - Ports: push, din, pop, dout, count, full, empty.
  - Synchronous on clock, same async active-low reset.
- RAM inferred inline.

Test Plan:
1. Store 32'hDEADBEEF to address 5, then load 5 on the next cycle -> q_dmem=32'hDEADBEEF one rising edge after the load address. Load 6 (never written after a known preload of 0) -> 0.
2. Push 'C','R','A','N','E' (0x43,0x52,0x41,0x4E,0x45) -> STATUS reads 0x51. Five KEY_DATA loads with rden return 0x43,0x52,0x41,0x4E,0x45 in order. STATUS then reads 0x00 and a sixth load returns 0.
3. Hold key_valid for 10 cycles with no reads -> key_ready drops after 8 pushes and STATUS reads 0x83. Write STATUS with data=2 -> reads 0x81.
4. With 3 entries queued, present key_valid and a KEY_DATA rden load in the same cycle -> count stays 3 and the oldest entry is returned. KEY_DATA with rden=0 -> head returned, count unchanged.
5. Write LED=32'h0000001F -> led_out=0x1F. Assert reset low mid-burst -> led_out=0, STATUS=0, key_ready=1 immediately (asynchronously).
6. With DMEM_MMIO_CYCLE_COUNTER_EN: write CYCLES=100, read on each of the next 3 cycles -> 101,102,103 as sampled at each rising edge. Without the macro -> 0.
